// File: rtl/wb_arbiter_pkg.sv
// Writeback arbiter shared types: the execute-stage result package, the source
// enumeration and default sizing. Imported by every writeback file.
package wb_arbiter_pkg;

    localparam int WB_NUM_SRC    = 4;
    localparam int WB_FIFO_DEPTH = 2;

    // Source index into the per-source result vectors.
    typedef enum logic [1:0] {
        WB_SRC_ALU,
        WB_SRC_MUL,
        WB_SRC_DIV,
        WB_SRC_LSU
    } wb_src_e;

    // Result package travelling from the execute units to the register file.
    typedef struct packed {
        logic [31:0] rd_data;
        logic [4:0]  rd_addr;
        logic        wren;
        logic        valid;
        logic        rd_is_int;
    } pipe_t;

    // A package only carries a writeback when it is both valid and writing.
    function automatic logic is_accepted(input pipe_t p);
        return p.valid & p.wren;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: per-source result packages in, flags, the registered
// writeback package and the performance counters out.
// master = execute side / environment, slave = the arbiter.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC
);

    pipe_t [NUM_SRC-1:0] i_src_pkg;
    logic  [NUM_SRC-1:0] o_src_full;
    logic                o_stall;
    pipe_t               o_wb_pkg;
    logic                o_overflow;
    logic  [31:0]        o_conflict_cnt;
    logic  [31:0]        o_retire_cnt;

    modport master (
        output i_src_pkg,
        input  o_src_full,
        input  o_stall,
        input  o_wb_pkg,
        input  o_overflow,
        input  o_conflict_cnt,
        input  o_retire_cnt
    );

    modport slave (
        input  i_src_pkg,
        output o_src_full,
        output o_stall,
        output o_wb_pkg,
        output o_overflow,
        output o_conflict_cnt,
        output o_retire_cnt
    );

endinterface

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO. Storage is read combinationally at the head so the
// arbiter can grant it in the same cycle; the arbiter itself bypasses the
// incoming package around an empty FIFO. Pointers carry one extra wrap bit so
// that the occupancy is simply their difference (DEPTH must be a power of 2).
module wb_src_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_d,
    output logic [WIDTH-1:0]       o_q,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + 1'b1;
            if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write storage; a push into a full FIFO is only issued together with a
    // pop, so it overwrites the slot whose head is leaving this cycle.
    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr[AW-1:0]] <= i_d;
    end

    assign o_q     = mem[rd_ptr[AW-1:0]];
    assign o_count = wr_ptr - rd_ptr;
    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from NUM_SRC execute units in per-source
// fall-through FIFOs and grants one per cycle, round-robin, to the single
// register-file write port through a registered output package.
// Optional feature macro: WB_PERF_EN enables the conflict and retire counters;
// without it both counter ports read 32'h0 and no counter logic is built.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = WB_NUM_SRC,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst,
    wb_arbiter_if.slave bus
);

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PKG_W = $bits(pipe_t);

    logic [NUM_SRC-1:0] acc;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] fifo_empty;
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] src_full;
    logic [CNT_W-1:0]   fifo_count [NUM_SRC];
    pipe_t              head_pkg   [NUM_SRC];
    pipe_t              cand_pkg   [NUM_SRC];

    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   rr_nxt;
    logic [SRC_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               ovf_set;
    logic               overflow;
    pipe_t              wb_pkg_p1;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [PKG_W-1:0] head_q;

        assign acc[i]      = is_accepted(bus.i_src_pkg[i]);
        assign head_pkg[i] = pipe_t'(head_q);
        // An empty FIFO lets the incoming package compete directly.
        assign cand[i]     = ~fifo_empty[i] | acc[i];
        assign cand_pkg[i] = fifo_empty[i] ? bus.i_src_pkg[i] : head_pkg[i];
        assign pop[i]      = grant[i] & ~fifo_empty[i];
        // Enqueue unless it left via fall-through, or would overflow a FIFO
        // whose head is not leaving this cycle.
        assign push[i]     = acc[i] & ~(fifo_empty[i] & grant[i])
                           & (~fifo_full[i] | grant[i]);
        assign src_full[i] = (fifo_count[i] == CNT_W'(FIFO_DEPTH));

        wb_src_fifo #(
            .WIDTH (PKG_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_push  (push[i]),
            .i_pop   (pop[i]),
            .i_d     (bus.i_src_pkg[i]),
            .o_q     (head_q),
            .o_empty (fifo_empty[i]),
            .o_full  (fifo_full[i]),
            .o_count (fifo_count[i])
        );
    end

    // Round-robin pick: first candidate at or after the rr pointer.
    always_comb begin
        logic [SRC_W-1:0] sel;
        sel     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sel = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!gnt_any && cand[sel]) begin
                gnt_any = 1'b1;
                gnt_idx = sel;
            end
        end
        grant[gnt_idx] = gnt_any;
    end

    assign rr_nxt  = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    assign ovf_set = |(acc & fifo_full & ~grant);

    // Round-robin pointer moves past the granted source, holds otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= rr_nxt;
    end

    // Sticky overflow: an accepted package was dropped at a full FIFO.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
    end

    // Writeback register: load the winner, else drop valid and hold the rest.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wb_pkg_p1 <= '0;
        end else if (gnt_any) begin
            wb_pkg_p1       <= cand_pkg[gnt_idx];
            wb_pkg_p1.valid <= 1'b1;
        end else begin
            wb_pkg_p1.valid <= 1'b0;
        end
    end

    assign bus.o_wb_pkg   = wb_pkg_p1;
    assign bus.o_src_full = src_full;
    assign bus.o_stall    = |src_full;
    assign bus.o_overflow = overflow;

`ifdef WB_PERF_EN
    logic [31:0] conflict_cnt;
    logic [31:0] retire_cnt;

    // Performance counters: contended cycles and granted packages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            conflict_cnt <= '0;
            retire_cnt   <= '0;
        end else begin
            if ($countones(cand) >= 2) conflict_cnt <= conflict_cnt + 32'd1;
            if (gnt_any)               retire_cnt   <= retire_cnt + 32'd1;
        end
    end

    assign bus.o_conflict_cnt = conflict_cnt;
    assign bus.o_retire_cnt   = retire_cnt;
`else
    assign bus.o_conflict_cnt = 32'h0;
    assign bus.o_retire_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic. A
// queue-based reference model predicts each cycle's writeback; a monitor
// compares the DUT against the predictions one cycle later.
`timescale 1ns/1ps
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N = 4;
    localparam int D = 2;
`ifdef WB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_SRC(N)) bus();

    wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        bit          vld;
        pipe_t       hold;
        bit [N-1:0]  full;
        bit          stall;
        bit          ovf;
        int unsigned conf;
        int unsigned ret;
    } stat_t;

    pipe_t exp_q [$];
    stat_t stat_q [$];

    // reference model state
    pipe_t       mq [N][$];
    int          rr;
    bit          m_ovf;
    int unsigned m_conf;
    int unsigned m_ret;
    pipe_t       m_last;

    int checks = 0;
    int errors = 0;

    pipe_t drv [N];
    pipe_t idle [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pipe_t mk(input bit v, input bit w, input logic [4:0] a, input logic [31:0] d);
        pipe_t p;
        p.rd_data   = d;
        p.rd_addr   = a;
        p.wren      = w;
        p.valid     = v;
        p.rd_is_int = d[0];
        return p;
    endfunction

    // One cycle of the writeback rules expressed with per-source queues.
    task automatic model_step(input pipe_t in [N]);
        bit    acc [N];
        bit    was_empty [N];
        bit    cand [N];
        int    g;
        int    nc;
        int    idx;
        stat_t s;
        pipe_t p;
        g  = -1;
        nc = 0;
        for (int i = 0; i < N; i++) begin
            acc[i]       = in[i].valid && in[i].wren;
            was_empty[i] = (mq[i].size() == 0);
            cand[i]      = !was_empty[i] || acc[i];
            if (cand[i]) nc++;
        end
        for (int k = 0; k < N; k++) begin
            idx = (rr + k) % N;
            if (g < 0 && cand[idx]) g = idx;
        end
        if (nc >= 2) m_conf++;
        s.vld = 1'b0;
        if (g >= 0) begin
            p = was_empty[g] ? in[g] : mq[g][0];
            p.valid = 1'b1;
            exp_q.push_back(p);
            m_last = p;
            m_ret++;
            rr = (g + 1) % N;
            s.vld = 1'b1;
            if (!was_empty[g]) void'(mq[g].pop_front());
        end else begin
            m_last.valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i] && !(i == g && was_empty[i])) begin
                if (mq[i].size() < D) mq[i].push_back(in[i]);
                else                  m_ovf = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) s.full[i] = (mq[i].size() == D);
        s.hold  = m_last;
        s.stall = |s.full;
        s.ovf   = m_ovf;
        s.conf  = PERF ? m_conf : 0;
        s.ret   = PERF ? m_ret : 0;
        stat_q.push_back(s);
    endtask

    task automatic cycle(input pipe_t in [N]);
        @(negedge clk);
        for (int i = 0; i < N; i++) bus.i_src_pkg[i] = in[i];
        model_step(in);
    endtask

    task automatic do_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) bus.i_src_pkg[i] = '0;
        rst = 1'b1;
        for (int i = 0; i < N; i++) mq[i].delete();
        rr = 0; m_ovf = 0; m_conf = 0; m_ret = 0; m_last = '0;
        exp_q.delete();
        stat_q.delete();
        #1;
        chk("rst_wb_pkg",   bus.o_wb_pkg,       '0);
        chk("rst_src_full", bus.o_src_full,     '0);
        chk("rst_stall",    bus.o_stall,        '0);
        chk("rst_overflow", bus.o_overflow,     '0);
        chk("rst_conflict", bus.o_conflict_cnt, '0);
        chk("rst_retire",   bus.o_retire_cnt,   '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit busy;
        for (int n = 0; n < 32; n++) begin
            busy = 1'b0;
            for (int i = 0; i < N; i++) if (mq[i].size() != 0) busy = 1'b1;
            if (!busy) break;
            cycle(idle);
        end
        cycle(idle);
        @(posedge clk); #2;
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic clear_drv();
        for (int i = 0; i < N; i++) drv[i] = '0;
    endtask

    // Monitor: one cycle after each model step, compare the DUT outputs.
    initial begin
        stat_t s;
        pipe_t e;
        forever begin
            @(posedge clk); #1;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("wb_valid", bus.o_wb_pkg.valid, s.vld);
                if (bus.o_wb_pkg.valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected actual=%0h required=none", bus.o_wb_pkg);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_pkg", bus.o_wb_pkg, e);
                    end
                end else begin
                    chk("wb_hold", bus.o_wb_pkg, s.hold);
                end
                chk("src_full", bus.o_src_full,     s.full);
                chk("stall",    bus.o_stall,        s.stall);
                chk("overflow", bus.o_overflow,     s.ovf);
                chk("conflict", bus.o_conflict_cnt, s.conf);
                chk("retire",   bus.o_retire_cnt,   s.ret);
            end else begin
                chk("idle_valid", bus.o_wb_pkg.valid, 1'b0);
            end
        end
    end

    initial begin
        int r;
        for (int i = 0; i < N; i++) begin
            idle[i] = '0;
            bus.i_src_pkg[i] = '0;
        end
        clear_drv();

        // single ALU result, latency 1
        do_reset();
        clear_drv();
        drv[WB_SRC_ALU] = mk(1, 1, 5'd5, 32'hDEAD_BEEF);
        cycle(drv);
        @(posedge clk); #2;
        chk("alu_valid", bus.o_wb_pkg.valid,   1'b1);
        chk("alu_addr",  bus.o_wb_pkg.rd_addr, 5'd5);
        chk("alu_data",  bus.o_wb_pkg.rd_data, 32'hDEAD_BEEF);
        chk("alu_full",  bus.o_src_full,       '0);
        drain("alu_drain");

        // ALU + LSU conflict from rr = 0
        do_reset();
        clear_drv();
        drv[WB_SRC_ALU] = mk(1, 1, 5'd1, 32'h1111_0000);
        drv[WB_SRC_LSU] = mk(1, 1, 5'd2, 32'h4444_0001);
        cycle(drv);
        @(posedge clk); #2;
        chk("conf_first", bus.o_wb_pkg.rd_data, 32'h1111_0000);
        cycle(idle);
        @(posedge clk); #2;
        chk("conf_second",   bus.o_wb_pkg.rd_data, 32'h4444_0001);
        chk("conf_cnt",      bus.o_conflict_cnt,   PERF ? 32'd1 : 32'd0);
        chk("conf_retire",   bus.o_retire_cnt,     PERF ? 32'd2 : 32'd0);
        drain("conf_drain");

        // MUL fills while the others win, third arrival overflows
        do_reset();
        clear_drv();
        drv[WB_SRC_MUL] = mk(1, 1, 5'd3, 32'h2000_0000);
        cycle(drv);
        for (int c = 1; c <= 4; c++) begin
            for (int i = 0; i < N; i++) drv[i] = mk(1, 1, 5'(8 + i), 32'(c * 16 + i));
            cycle(drv);
            @(posedge clk); #2;
            if (c == 2) begin
                chk("fill_mul_full", bus.o_src_full[WB_SRC_MUL], 1'b1);
                chk("fill_stall",    bus.o_stall,                1'b1);
                chk("fill_no_ovf",   bus.o_overflow,             1'b0);
            end
            if (c == 3) chk("fill_ovf", bus.o_overflow, 1'b1);
        end
        drain("fill_drain");

        // MUL full with its head granted and a new arrival: no overflow
        do_reset();
        clear_drv();
        drv[WB_SRC_MUL] = mk(1, 1, 5'd7, 32'h3000_0000);
        cycle(drv);
        clear_drv();
        drv[WB_SRC_MUL] = mk(1, 1, 5'd7, 32'h3000_0001);
        drv[WB_SRC_DIV] = mk(1, 1, 5'd9, 32'h5000_0000);
        cycle(drv);
        clear_drv();
        drv[WB_SRC_MUL] = mk(1, 1, 5'd7, 32'h3000_0002);
        drv[WB_SRC_LSU] = mk(1, 1, 5'd0, 32'h6000_0000);
        cycle(drv);
        @(posedge clk); #2;
        chk("pop_full_before", bus.o_src_full[WB_SRC_MUL], 1'b1);
        for (int c = 3; c <= 4; c++) begin
            clear_drv();
            drv[WB_SRC_MUL] = mk(1, 1, 5'd7, 32'h3000_0000 + 32'(c));
            cycle(drv);
            @(posedge clk); #2;
            chk("pop_full_data", bus.o_wb_pkg.rd_data, 32'h3000_0000 + 32'(c - 2));
            chk("pop_full_cnt",  bus.o_src_full[WB_SRC_MUL], 1'b1);
            chk("pop_full_ovf",  bus.o_overflow, 1'b0);
        end
        drain("pop_full_drain");

        // dropped packages
        do_reset();
        clear_drv();
        drv[WB_SRC_ALU] = mk(1, 0, 5'd4, 32'hBAD0_0001);
        drv[WB_SRC_MUL] = mk(0, 1, 5'd4, 32'hBAD0_0002);
        cycle(drv);
        @(posedge clk); #2;
        chk("drop_valid", bus.o_wb_pkg.valid, 1'b0);
        chk("drop_full",  bus.o_src_full,     '0);
        drain("drop_drain");

        // reset with MUL entries buffered and overflow set
        do_reset();
        clear_drv();
        drv[WB_SRC_MUL] = mk(1, 1, 5'd6, 32'h7000_0000);
        cycle(drv);
        drv[WB_SRC_DIV] = mk(1, 1, 5'd6, 32'h7000_0001);
        drv[WB_SRC_MUL] = mk(1, 1, 5'd6, 32'h7000_0002);
        cycle(drv);
        clear_drv();
        drv[WB_SRC_MUL] = mk(1, 1, 5'd6, 32'h7000_0003);
        drv[WB_SRC_LSU] = mk(1, 1, 5'd6, 32'h7000_0004);
        cycle(drv);
        clear_drv();
        drv[WB_SRC_MUL] = mk(1, 1, 5'd6, 32'h7000_0005);
        drv[WB_SRC_ALU] = mk(1, 1, 5'd6, 32'h7000_0006);
        cycle(drv);
        @(posedge clk); #2;
        chk("midrst_pre_ovf", bus.o_overflow, 1'b1);
        do_reset();
        repeat (4) cycle(idle);
        drain("midrst_drain");

        // randomized traffic, mostly honouring the full flags
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                r = int'($urandom_range(0, 9));
                if (mq[i].size() == D && $urandom_range(0, 9) != 0) begin
                    drv[i] = '0;
                end else if (r <= 3) begin
                    drv[i] = mk(1, 1, 5'($urandom_range(0, 31)), $urandom);
                end else if (r == 4) begin
                    drv[i] = mk(1, 0, 5'($urandom_range(0, 31)), $urandom);
                end else if (r == 5) begin
                    drv[i] = mk(0, 1, 5'($urandom_range(0, 31)), $urandom);
                end else begin
                    drv[i] = '0;
                end
            end
            cycle(drv);
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
